// File: rtl/uart_tx_core.sv
// UART transmitter: start, DATA_BITS LSB first, optional parity, 1-2 stop bits.
// Define UART_TX_BUSY_EN to add the busy output (equal to !ready).
module uart_tx_core #(
  parameter int DATA_BITS   = 8,
  parameter int BAUD_RATE   = 9600,
  parameter int SYS_CLK     = 100_000_000,
  parameter int STOP_BITS   = 1,
  parameter int HAS_PARITY  = 1,
  parameter int PARITY_EVEN = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 valid,
  output logic                 ready,
  output logic                 sig
`ifdef UART_TX_BUSY_EN
  ,
  output logic                 busy
`endif
);

  localparam int CLKS_PER_BIT = SYS_CLK / BAUD_RATE;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = $clog2(DATA_BITS);
  localparam logic PODD = (PARITY_EVEN == 0);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e               state_q;
  logic [CW-1:0]        cnt_q;
  logic [IW-1:0]        idx_q;
  logic                 stop_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_q;
  logic                 sig_q;
  logic                 ready_q;
  logic                 bit_end;

  assign bit_end = (cnt_q == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      par_q   <= 1'b0;
      sig_q   <= 1'b1;
      ready_q <= 1'b1;
    end else begin
      cnt_q <= cnt_q + CW'(1);
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (valid && ready_q) begin
            shift_q <= data;
            // parity is kept aside since the shift register is consumed
            par_q   <= (^data) ^ PODD;
            state_q <= START;
            sig_q   <= 1'b0;
            ready_q <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= DATA;
            sig_q   <= shift_q[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt_q   <= '0;
            shift_q <= shift_q >> 1;
            if (idx_q == IW'(DATA_BITS - 1)) begin
              if (HAS_PARITY != 0) begin
                state_q <= PARITY;
                sig_q   <= par_q;
              end else begin
                state_q <= STOP;
                stop_q  <= 1'b0;
                sig_q   <= 1'b1;
              end
            end else begin
              idx_q <= idx_q + IW'(1);
              sig_q <= shift_q[1];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            cnt_q   <= '0;
            state_q <= STOP;
            stop_q  <= 1'b0;
            sig_q   <= 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (stop_q == 1'(STOP_BITS - 1)) begin
              state_q <= IDLE;
              ready_q <= 1'b1;
            end else begin
              stop_q <= stop_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          sig_q   <= 1'b1;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready = ready_q;
  assign sig   = sig_q;

`ifdef UART_TX_BUSY_EN
  assign busy = !ready_q;
`endif

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core at 16 clocks per bit.
module tb_uart_tx_core;

  localparam int C = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data0 = '0, data1 = '0, data2 = '0;
  logic       valid0 = 0, valid1 = 0, valid2 = 0;
  logic       ready0, ready1, ready2;
  logic       sig0, sig1, sig2;
`ifdef UART_TX_BUSY_EN
  logic       busy0, busy1, busy2;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  int sel = 0;
  logic sig_m, ready_m;

  always #5 clk = ~clk;

  uart_tx_core #(.SYS_CLK(160), .BAUD_RATE(10)) u0 (
    .clk(clk), .reset(reset), .data(data0), .valid(valid0),
    .ready(ready0), .sig(sig0)
`ifdef UART_TX_BUSY_EN
    , .busy(busy0)
`endif
  );

  uart_tx_core #(.SYS_CLK(160), .BAUD_RATE(10),
                 .PARITY_EVEN(0)) u1 (
    .clk(clk), .reset(reset), .data(data1), .valid(valid1),
    .ready(ready1), .sig(sig1)
`ifdef UART_TX_BUSY_EN
    , .busy(busy1)
`endif
  );

  uart_tx_core #(.SYS_CLK(160), .BAUD_RATE(10),
                 .HAS_PARITY(0), .STOP_BITS(2)) u2 (
    .clk(clk), .reset(reset), .data(data2), .valid(valid2),
    .ready(ready2), .sig(sig2)
`ifdef UART_TX_BUSY_EN
    , .busy(busy2)
`endif
  );

  always_comb begin
    sig_m = sig0;
    ready_m = ready0;
    case (sel)
      1: begin sig_m = sig1; ready_m = ready1; end
      2: begin sig_m = sig2; ready_m = ready2; end
      default: ;
    endcase
  end

  task automatic send(input int k, input logic [7:0] d);
    @(negedge clk);
    case (k)
      0: begin data0 = d; valid0 = 1; end
      1: begin data1 = d; valid1 = 1; end
      default: begin data2 = d; valid2 = 1; end
    endcase
    @(posedge clk);
    @(negedge clk);
    valid0 = 0; valid1 = 0; valid2 = 0;
  endtask

  // Entered at the first negedge after the handshake edge.
  task automatic capture(output logic [15:0] b, output int len,
                         output logic first);
    b = '0;
    len = 0;
    first = sig_m;
    while (ready_m === 1'b0 && len < 2000) begin
      if (len % C == C / 2) b[len / C] = sig_m;
      len++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({sig0, sig1, sig2} !== 3'b111) begin
      tests_failed++;
      $display("FAIL reset_sig got %b want 111", {sig0, sig1, sig2});
    end
    tests_run++;
    if ({ready0, ready1, ready2} !== 3'b111) begin
      tests_failed++;
      $display("FAIL reset_ready got %b want 111",
               {ready0, ready1, ready2});
    end
`ifdef UART_TX_BUSY_EN
    tests_run++;
    if ({busy0, busy1, busy2} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_busy got %b want 000", {busy0, busy1, busy2});
    end
`endif
    reset = 1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (sig0 !== 1'b1 || ready0 !== 1'b1) begin
      tests_failed++;
      $display("FAIL idle_after_reset sig=%b ready=%b want 1 1",
               sig0, ready0);
    end
  endtask

  task automatic test_frames;
    logic [7:0]  words [4] = '{8'hA5, 8'h5A, 8'hFF, 8'h00};
    logic [10:0] exp   [4] = '{
      {1'b1, 1'b0, 8'hA5, 1'b0},
      {1'b1, 1'b0, 8'h5A, 1'b0},
      {1'b1, 1'b0, 8'hFF, 1'b0},
      {1'b1, 1'b0, 8'h00, 1'b0}};
    logic [15:0] b;
    int len;
    logic first;
    sel = 0;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (sig0 !== 1'b1) begin
        tests_failed++;
        $display("FAIL pre_frame_%0d sig=%b want 1", i, sig0);
      end
      send(0, words[i]);
      capture(b, len, first);
      tests_run++;
      if (first !== 1'b0) begin
        tests_failed++;
        $display("FAIL start_%0d sig=%b want 0", i, first);
      end
      tests_run++;
      if (b[10:0] !== exp[i]) begin
        tests_failed++;
        $display("FAIL bits_%0d got %b want %b", i, b[10:0], exp[i]);
      end
      tests_run++;
      if (len != 11 * C) begin
        tests_failed++;
        $display("FAIL len_%0d got %0d want %0d", i, len, 11 * C);
      end
    end
  endtask

  task automatic test_parity;
    logic [15:0] b;
    int len;
    logic first;
    sel = 1;
    send(1, 8'h01);
    capture(b, len, first);
    tests_run++;
    if (b[10:0] !== {1'b1, 1'b0, 8'h01, 1'b0}) begin
      tests_failed++;
      $display("FAIL odd_parity got %b want %b", b[10:0],
               {1'b1, 1'b0, 8'h01, 1'b0});
    end
    sel = 0;
    send(0, 8'h01);
    capture(b, len, first);
    tests_run++;
    if (b[10:0] !== {1'b1, 1'b1, 8'h01, 1'b0}) begin
      tests_failed++;
      $display("FAIL even_parity got %b want %b", b[10:0],
               {1'b1, 1'b1, 8'h01, 1'b0});
    end
  endtask

  task automatic test_no_parity_two_stop;
    logic [15:0] b;
    int len;
    logic first;
    sel = 2;
    send(2, 8'hC3);
    capture(b, len, first);
    tests_run++;
    if (b[10:0] !== {2'b11, 8'hC3, 1'b0}) begin
      tests_failed++;
      $display("FAIL np2s_bits got %b want %b", b[10:0],
               {2'b11, 8'hC3, 1'b0});
    end
    tests_run++;
    if (len != 11 * C) begin
      tests_failed++;
      $display("FAIL np2s_len got %0d want %0d", len, 11 * C);
    end
    sel = 0;
  endtask

  task automatic test_back_to_back;
    logic [15:0] b;
    int len;
    logic first;
    sel = 0;
    @(negedge clk);
    data0 = 8'h12;
    valid0 = 1;
    @(posedge clk);
    @(negedge clk);
    data0 = 8'h34;
    capture(b, len, first);
    tests_run++;
    if (b[10:0] !== {1'b1, 1'b0, 8'h12, 1'b0} || len != 11 * C) begin
      tests_failed++;
      $display("FAIL b2b_first got %b len %0d want %b len %0d",
               b[10:0], len, {1'b1, 1'b0, 8'h12, 1'b0}, 11 * C);
    end
    tests_run++;
    if (sig0 !== 1'b1 || ready0 !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_gap sig=%b ready=%b want 1 1", sig0, ready0);
    end
    @(posedge clk);
    @(negedge clk);
    valid0 = 0;
    capture(b, len, first);
    tests_run++;
    if (first !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_start sig=%b want 0", first);
    end
    tests_run++;
    if (b[10:0] !== {1'b1, 1'b1, 8'h34, 1'b0} || len != 11 * C) begin
      tests_failed++;
      $display("FAIL b2b_second got %b len %0d want %b len %0d",
               b[10:0], len, {1'b1, 1'b1, 8'h34, 1'b0}, 11 * C);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [15:0] b;
    int len;
    logic first;
    sel = 0;
    send(0, 8'hA5);
    repeat (3 * C + 3) @(negedge clk);
    tests_run++;
    if (ready0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_busy ready=%b want 0", ready0);
    end
    #2 reset = 0;
    #1;
    tests_run++;
    if (sig0 !== 1'b1 || ready0 !== 1'b1) begin
      tests_failed++;
      $display("FAIL async_reset sig=%b ready=%b want 1 1", sig0, ready0);
    end
    @(negedge clk);
    reset = 1;
    repeat (5 * C) @(negedge clk);
    tests_run++;
    if (sig0 !== 1'b1 || ready0 !== 1'b1) begin
      tests_failed++;
      $display("FAIL no_resume sig=%b ready=%b want 1 1", sig0, ready0);
    end
    send(0, 8'hA5);
    capture(b, len, first);
    tests_run++;
    if (first !== 1'b0 || b[10:0] !== {1'b1, 1'b0, 8'hA5, 1'b0} ||
        len != 11 * C) begin
      tests_failed++;
      $display("FAIL post_reset got %b len %0d want %b len %0d",
               b[10:0], len, {1'b1, 1'b0, 8'hA5, 1'b0}, 11 * C);
    end
  endtask

  initial begin
    test_reset();
    test_frames();
    test_parity();
    test_no_parity_two_stop();
    test_back_to_back();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
